fill_offset_encoder: RTL and testbench

FILL_OFFSET_ENCODER -- requirements
Module: fill_offset_encoder

---
 rtl/fill_offset_encoder_if.sv | 36 +++
 rtl/fill_offset_encoder.sv | 136 +++++++++++++
 tb/tb_fill_offset_encoder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fill_offset_encoder_if.sv
// rtl/fill_offset_encoder_if.sv - signal bundle between a fill requester and the fill offset encoder
//
// Purpose: groups the fill request, returning-word and status signals of the
//          fill offset encoder so they travel as one port.
// Signals:
//   start, set_enable[63:0], abort       fill request / cancel (requester -> encoder)
//   word_valid, word_select[7:0]         returning memory word (requester -> encoder)
//   busy, set_index[5:0], set_err        fill status (encoder -> requester)
//   offset[2:0], offset_valid, word_err  per-word result (encoder -> requester)
//   filled[7:0], fill_done               fill progress (encoder -> requester)
// Modports: master drives requests, slave is the encoder.
interface fill_offset_encoder_if;
  logic        start;
  logic [63:0] set_enable;
  logic        abort;
  logic        word_valid;
  logic [7:0]  word_select;
  logic        busy;
  logic [5:0]  set_index;
  logic        set_err;
  logic [2:0]  offset;
  logic        offset_valid;
  logic        word_err;
  logic [7:0]  filled;
  logic        fill_done;

  modport master (
    output start, set_enable, abort, word_valid, word_select,
    input  busy, set_index, set_err, offset, offset_valid, word_err, filled, fill_done
  );

  modport slave (
    input  start, set_enable, abort, word_valid, word_select,
    output busy, set_index, set_err, offset, offset_valid, word_err, filled, fill_done
  );
endinterface

// File: rtl/fill_offset_encoder.sv
// rtl/fill_offset_encoder.sv - tracks an 8-word block fill and encodes set and word positions
//
// Purpose: on start, latches the binary encoding of a one-hot set select, then
//          accepts the 8 words of the block in any order, reporting each
//          accepted word's binary offset and rejecting bad or duplicate words.
//          Pulses fill_done once all 8 words are in.
// Ports:
//   clk  sole clock, rising edge
//   rst  asynchronous active-high reset
//   bus  fill_offset_encoder_if.slave (request inputs, registered status outputs)
module fill_offset_encoder (
  input logic                  clk,
  input logic                  rst,
  fill_offset_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic        busy_q;
  logic [5:0]  set_index_q;
  logic        set_err_q;
  logic [2:0]  offset_q;
  logic        offset_valid_q;
  logic        word_err_q;
  logic [7:0]  filled_q;
  logic        fill_done_q;

  // OR-ing the positions of all set bits gives the index when exactly one is set;
  // callers discard the result otherwise.
  function automatic logic [5:0] encode64(input logic [63:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] encode8(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

  logic        set_onehot;
  logic [5:0]  set_idx;
  logic        word_onehot;
  logic [2:0]  word_idx;
  logic        word_ok;
  logic [7:0]  filled_next;

  always_comb begin
    set_onehot  = ($countones(bus.set_enable) == 1);
    set_idx     = set_onehot ? encode64(bus.set_enable) : 6'd0;
    word_onehot = ($countones(bus.word_select) == 1);
    word_idx    = encode8(bus.word_select);
    // A word is accepted only if it names a single position not yet filled.
    word_ok     = word_onehot && !filled_q[word_idx];
    filled_next = filled_q | bus.word_select;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      busy_q         <= 1'b0;
      set_index_q    <= '0;
      set_err_q      <= 1'b0;
      offset_q       <= '0;
      offset_valid_q <= 1'b0;
      word_err_q     <= 1'b0;
      filled_q       <= '0;
      fill_done_q    <= 1'b0;
    end else begin
      offset_valid_q <= 1'b0;
      word_err_q     <= 1'b0;
      fill_done_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= FILL;
            busy_q      <= 1'b1;
            set_index_q <= set_idx;
            set_err_q   <= !set_onehot;
            filled_q    <= '0;
          end
        end
        FILL: begin
          // abort wins over a word returning in the same cycle
          if (bus.abort) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            filled_q <= '0;
          end else if (bus.word_valid) begin
            if (word_ok) begin
              offset_q       <= word_idx;
              offset_valid_q <= 1'b1;
              filled_q       <= filled_next;
              if (filled_next == 8'hFF) begin
                state       <= DONE;
                fill_done_q <= 1'b1;
              end
            end else begin
              word_err_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.set_index    = set_index_q;
  assign bus.set_err      = set_err_q;
  assign bus.offset       = offset_q;
  assign bus.offset_valid = offset_valid_q;
  assign bus.word_err     = word_err_q;
  assign bus.filled       = filled_q;
  assign bus.fill_done    = fill_done_q;

endmodule

// File: tb/tb_fill_offset_encoder.sv
// tb/tb_fill_offset_encoder.sv - self-checking bench for fill_offset_encoder
//
// Purpose: drives block fills through the encoder and checks status outputs
//          inline, with per-word results checked from a scoreboard queue.
// Ports: none (top-level bench).
module tb_fill_offset_encoder;

  logic clk;
  logic rst;

  fill_offset_encoder_if bus ();

  fill_offset_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [2:0] off;
    logic [7:0] filled;
  } exp_t;

  exp_t       exp_q[$];
  int         vectors;
  int         miscompares;
  bit         m_fill;
  logic [7:0] m_filled;
  logic [2:0] m_offset;

  // Per-word results are checked half a cycle after the edge that produced them.
  always @(negedge clk) begin
    if (!rst && (bus.offset_valid || bus.word_err)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: offset_valid=%b word_err=%b, required none", bus.offset_valid, bus.word_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.word_err !== e.is_err || bus.offset_valid !== !e.is_err ||
            bus.offset !== e.off || bus.filled !== e.filled) begin
          miscompares++;
          $display("FAIL word_result: err=%b valid=%b offset=%0d filled=%h, required err=%b valid=%b offset=%0d filled=%h",
                   bus.word_err, bus.offset_valid, bus.offset, bus.filled,
                   e.is_err, !e.is_err, e.off, e.filled);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.set_enable  = '0;
    bus.abort       = 1'b0;
    bus.word_valid  = 1'b0;
    bus.word_select = '0;
  endtask

  task automatic start_fill(input logic [63:0] se, input logic [5:0] exp_idx, input logic exp_err);
    bus.start      = 1'b1;
    bus.set_enable = se;
    tick();
    bus.start      = 1'b0;
    m_fill   = 1'b1;
    m_filled = '0;
    if (bus.busy !== 1'b1 || bus.set_index !== exp_idx || bus.set_err !== exp_err || bus.filled !== 8'h00) begin
      miscompares++;
      $display("FAIL start_fill: busy=%b idx=%0d err=%b filled=%h, required busy=1 idx=%0d err=%b filled=00",
               bus.busy, bus.set_index, bus.set_err, bus.filled, exp_idx, exp_err);
    end
    vectors++;
  endtask

  // Pushes the expected result from the bench's own view of the fill, then applies the word.
  task automatic send_word(input logic [7:0] sel);
    exp_t e;
    int   j;
    j = -1;
    for (int i = 0; i < 8; i++) if (sel == (8'h01 << i)) j = i;
    if (m_fill) begin
      if (j >= 0 && !m_filled[j]) begin
        m_filled = m_filled | sel;
        m_offset = 3'(j);
        e.is_err = 1'b0;
      end else begin
        e.is_err = 1'b1;
      end
      e.off    = m_offset;
      e.filled = m_filled;
      exp_q.push_back(e);
      if (m_filled == 8'hFF) m_fill = 1'b0;
    end
    bus.word_valid  = 1'b1;
    bus.word_select = sel;
    tick();
    bus.word_valid  = 1'b0;
    bus.word_select = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_set_index", 64'(bus.set_index), 64'd0);
    check("reset_set_err", 64'(bus.set_err), 64'd0);
    check("reset_offset", 64'(bus.offset), 64'd0);
    check("reset_pulses", 64'({bus.offset_valid, bus.word_err, bus.fill_done}), 64'd0);
    check("reset_filled", 64'(bus.filled), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_fill   = 1'b0;
    m_filled = '0;
    m_offset = '0;
    tick();
  endtask

  task automatic test_in_order();
    start_fill(64'd1 << 37, 6'd37, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_word(8'h01 << i);
      check("in_order_fill_done", 64'(bus.fill_done), (i == 7) ? 64'd1 : 64'd0);
    end
    check("in_order_filled", 64'(bus.filled), 64'hFF);
    check("in_order_busy_done", 64'(bus.busy), 64'd1);
    tick();
    check("in_order_busy_after", 64'(bus.busy), 64'd0);
    check("in_order_done_pulse", 64'(bus.fill_done), 64'd0);
    check("in_order_filled_held", 64'(bus.filled), 64'hFF);
    check("in_order_offset_held", 64'(bus.offset), 64'd7);
  endtask

  task automatic test_ignored();
    bus.word_valid  = 1'b1;
    bus.word_select = 8'h01;
    tick();
    idle_inputs();
    check("idle_word_pulse", 64'({bus.offset_valid, bus.word_err}), 64'd0);
    check("idle_word_filled", 64'(bus.filled), 64'hFF);
    check("idle_word_busy", 64'(bus.busy), 64'd0);
    start_fill(64'd1 << 3, 6'd3, 1'b0);
    bus.start      = 1'b1;
    bus.set_enable = 64'd1 << 10;
    tick();
    idle_inputs();
    check("fill_start_ignored_idx", 64'(bus.set_index), 64'd3);
    check("fill_start_ignored_busy", 64'(bus.busy), 64'd1);
    bus.abort = 1'b1;
    tick();
    idle_inputs();
    m_fill = 1'b0;
    check("ignored_abort_busy", 64'(bus.busy), 64'd0);
  endtask

  task automatic test_out_of_order();
    logic [7:0] seq [9];
    seq = '{8'h20, 8'h04, 8'h20, 8'h01, 8'h02, 8'h08, 8'h10, 8'h40, 8'h80};
    start_fill(64'd1, 6'd0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      send_word(seq[i]);
      if (i == 2) begin
        check("dup_word_err", 64'(bus.word_err), 64'd1);
        check("dup_filled", 64'(bus.filled), 64'h24);
      end
      check("ooo_fill_done", 64'(bus.fill_done), (i == 8) ? 64'd1 : 64'd0);
    end
    check("ooo_filled", 64'(bus.filled), 64'hFF);
    tick();
  endtask

  task automatic test_bad_encoding();
    start_fill(64'h3, 6'd0, 1'b1);
    send_word(8'h02);
    send_word(8'h00);
    check("zero_word_err", 64'(bus.word_err), 64'd1);
    check("zero_word_offset", 64'(bus.offset), 64'd1);
    send_word(8'h81);
    check("multi_word_err", 64'(bus.word_err), 64'd1);
    check("multi_word_filled", 64'(bus.filled), 64'h02);
    bus.abort = 1'b1;
    tick();
    idle_inputs();
    m_fill = 1'b0;
  endtask

  task automatic test_abort();
    start_fill(64'd1 << 63, 6'd63, 1'b0);
    send_word(8'h01);
    send_word(8'h02);
    send_word(8'h04);
    bus.abort       = 1'b1;
    bus.word_valid  = 1'b1;
    bus.word_select = 8'h08;
    tick();
    idle_inputs();
    m_fill = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_filled", 64'(bus.filled), 64'd0);
    check("abort_pulses", 64'({bus.offset_valid, bus.fill_done}), 64'd0);
    start_fill(64'd1 << 5, 6'd5, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    for (int i = 0; i < 4; i++) send_word(8'h01 << i);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_set_index", 64'(bus.set_index), 64'd0);
    check("midrst_offset", 64'(bus.offset), 64'd0);
    check("midrst_filled", 64'(bus.filled), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    m_fill   = 1'b0;
    m_filled = '0;
    bus.word_valid  = 1'b1;
    bus.word_select = 8'h10;
    tick();
    idle_inputs();
    tick();
    check("post_rst_word_ignored", 64'({bus.offset_valid, bus.word_err, bus.busy}), 64'd0);
    check("post_rst_filled", 64'(bus.filled), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_in_order();
    test_ignored();
    test_out_of_order();
    test_bad_encoding();
    test_abort();
    test_reset_mid_fill();
    tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
